// File: rtl/star_pkg.sv
// star_pkg: constants shared by the star scanner and the downstream
// top/bottom search block, plus the scanner state encoding.
//   - image geometry (WIDTH x HEIGHT) and coordinate/address widths
//   - pixel width and brightness threshold
//   - star counter width
//   - scanner state encoding (3-bit) and its enum type
package star_pkg;

  localparam int X_SZ      = 3;
  localparam int Y_SZ      = 3;
  localparam int ADDR_SZ   = 6;
  localparam int COL_SZ    = 3;
  localparam int WIDTH     = 6;
  localparam int HEIGHT    = 6;
  localparam int THRESHOLD = 0;
  localparam int CNT_SZ    = 4;

  // Scanner state encoding
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SET_ADDR = 3'd1;
  localparam logic [2:0] ST_WAIT_RD  = 3'd2;
  localparam logic [2:0] ST_CHECK    = 3'd3;
  localparam logic [2:0] ST_FOUND    = 3'd4;
  localparam logic [2:0] ST_WAIT_ACK = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    SET_ADDR = ST_SET_ADDR,
    WAIT_RD  = ST_WAIT_RD,
    CHECK    = ST_CHECK,
    FOUND    = ST_FOUND,
    WAIT_ACK = ST_WAIT_ACK,
    DONE     = ST_DONE
  } scanState_t;

endpackage

// File: rtl/address_translator.sv
// address_translator: maps (x, y) image coordinates to a linear RAM address.
//   x    in  X_SZ     column
//   y    in  Y_SZ     row
//   addr out ADDR_SZ  y*WIDTH + x
module address_translator
  import star_pkg::*;
(
  input  logic [X_SZ-1:0]    x,
  input  logic [Y_SZ-1:0]    y,
  output logic [ADDR_SZ-1:0] addr
);

  assign addr = ADDR_SZ'(ADDR_SZ'(y) * ADDR_SZ'(WIDTH)) + ADDR_SZ'(x);

endmodule

// File: rtl/star_scanner.sv
// star_scanner: raster-scans the 6x6 image RAM for bright pixels (> THRESHOLD),
// reports each hit to the downstream search block and resumes scanning on the
// row below the star's reported bottom once the downstream side completes.
//   clk            in   clock, rising edge
//   reset          in   asynchronous active-high reset
//   start          in   begins a frame scan from (0,0) when in IDLE/DONE
//   mem_addr       out  RAM read address (y*WIDTH + x of scan counters)
//   mem_q          in   RAM data, valid one clock after mem_addr
//   star_found     out  one-cycle pulse per star
//   x_out, y_out   out  coordinates of the last star found
//   complete_in    in   downstream search finished (honoured in WAIT_ACK only)
//   most_bottom_in in   downstream bottom row of the current star
//   star_count     out  stars found this frame, saturating
//   scan_busy      out  high outside IDLE/DONE
//   scan_done      out  high in DONE
//   scan_state     out  current FSM state (debug)
//
// Handshake: star_found is a single-cycle notification with no ready; the
// downstream acknowledges with a complete_in pulse, which only counts while
// the scanner sits in WAIT_ACK (a complete held over from the previous star
// during FOUND is ignored).
module star_scanner
  import star_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [ADDR_SZ-1:0] mem_addr,
  input  logic [COL_SZ-1:0]  mem_q,
  output logic               star_found,
  output logic [X_SZ-1:0]    x_out,
  output logic [Y_SZ-1:0]    y_out,
  input  logic               complete_in,
  input  logic [Y_SZ-1:0]    most_bottom_in,
  output logic [CNT_SZ-1:0]  star_count,
  output logic               scan_busy,
  output logic               scan_done,
  output logic [2:0]         scan_state
);

  localparam logic [X_SZ-1:0]   X_LAST = X_SZ'(WIDTH - 1);
  localparam logic [Y_SZ-1:0]   Y_LAST = Y_SZ'(HEIGHT - 1);
  localparam logic [COL_SZ-1:0] THR    = COL_SZ'(THRESHOLD);

  scanState_t        state;
  logic [X_SZ-1:0]   x;
  logic [Y_SZ-1:0]   y;

  address_translator u_addr (
    .x    (x),
    .y    (y),
    .addr (mem_addr)
  );

  assign scan_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      x_out      <= '0;
      y_out      <= '0;
      star_count <= '0;
      star_found <= 1'b0;
      scan_busy  <= 1'b0;
      scan_done  <= 1'b0;
    end else begin
      star_found <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            x          <= '0;
            y          <= '0;
            star_count <= '0;
            scan_busy  <= 1'b1;
            scan_done  <= 1'b0;
            state      <= SET_ADDR;
          end
        end
        SET_ADDR: state <= WAIT_RD;
        // RAM latency: mem_q for the current address is valid from here on
        WAIT_RD:  state <= CHECK;
        CHECK: begin
          if (mem_q > THR) begin
            x_out      <= x;
            y_out      <= y;
            star_found <= 1'b1;   // high exactly while in FOUND
            state      <= FOUND;
          end else if (x != X_LAST) begin
            x     <= x + X_SZ'(1);
            state <= SET_ADDR;
          end else if (y != Y_LAST) begin
            x     <= '0;
            y     <= y + Y_SZ'(1);
            state <= SET_ADDR;
          end else begin
            scan_busy <= 1'b0;
            scan_done <= 1'b1;
            state     <= DONE;
          end
        end
        FOUND: state <= WAIT_ACK;
        WAIT_ACK: begin
          if (complete_in) begin
            if (star_count != '1) star_count <= star_count + CNT_SZ'(1);
            // A bottom above the star's own row means the downstream search
            // wrapped; treat it like reaching the last row.
            if (most_bottom_in >= Y_LAST || most_bottom_in < y_out) begin
              scan_busy <= 1'b0;
              scan_done <= 1'b1;
              state     <= DONE;
            end else begin
              x     <= '0;
              y     <= most_bottom_in + Y_SZ'(1);
              state <= SET_ADDR;
            end
          end
        end
        default: begin
          scan_busy <= 1'b0;
          scan_done <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_star_scanner.sv
// tb_star_scanner: randomized and directed frames against a reference model
// that predicts, from the image contents and the downstream responses, which
// stars are reported, at which cycle, and when the frame completes.
module tb_star_scanner;
  import star_pkg::*;

  localparam int NPIX = WIDTH * HEIGHT;

  typedef struct packed {
    logic              kind;   // 1 = star_found, 0 = scan_done rise
    logic [X_SZ-1:0]   x;
    logic [Y_SZ-1:0]   y;
    logic [CNT_SZ-1:0] cnt;
    logic [15:0]       cyc;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic               start = 1'b0;
  logic [ADDR_SZ-1:0] mem_addr;
  logic [COL_SZ-1:0]  mem_q;
  logic               star_found;
  logic [X_SZ-1:0]    x_out;
  logic [Y_SZ-1:0]    y_out;
  logic               complete_in = 1'b0;
  logic [Y_SZ-1:0]    most_bottom_in = '0;
  logic [CNT_SZ-1:0]  star_count;
  logic               scan_busy;
  logic               scan_done;
  logic [2:0]         scan_state;

  star_scanner dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .mem_addr       (mem_addr),
    .mem_q          (mem_q),
    .star_found     (star_found),
    .x_out          (x_out),
    .y_out          (y_out),
    .complete_in    (complete_in),
    .most_bottom_in (most_bottom_in),
    .star_count     (star_count),
    .scan_busy      (scan_busy),
    .scan_done      (scan_done),
    .scan_state     (scan_state)
  );

  // Image RAM with one clock of read latency
  logic [COL_SZ-1:0] img [NPIX];
  always @(posedge clk)
    mem_q <= (int'(mem_addr) < NPIX) ? img[int'(mem_addr)] : '0;

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int modelCount = 0;
  exp_t lastEv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input bit kind, input int px, input int py, input int ecyc);
    exp_t e;
    e.kind = kind;
    e.x    = X_SZ'(px);
    e.y    = Y_SZ'(py);
    e.cnt  = CNT_SZ'(modelCount);
    e.cyc  = 16'(ecyc);
    lastEv = e;
    exp_q.push_back(e);
  endtask

  // Reference: scanning starts at linear pixel s with the first address
  // presented at cycle t0; each pixel takes three cycles, a hit is reported
  // the cycle after its check, and an exhausted frame ends likewise.
  task automatic push_scan(input int s, input int t0);
    for (int k = s; k < NPIX; k++) begin
      if (int'(img[k]) > THRESHOLD) begin
        push_ev(1'b1, k % WIDTH, k / WIDTH, t0 + 3 + 3 * (k - s));
        return;
      end
    end
    push_ev(1'b0, 0, 0, t0 + 3 + 3 * (NPIX - 1 - s));
  endtask

  // Monitor
  logic prevDone = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prevDone = 1'b0;
    end else begin
      if (star_found) begin
        if (exp_q.size() == 0) check("unexpected star_found", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("event kind star", 1, 32'(e.kind));
          check("star cycle", cyc, 32'(e.cyc));
          check("x_out", 32'(x_out), 32'(e.x));
          check("y_out", 32'(y_out), 32'(e.y));
          check("star_count at hit", 32'(star_count), 32'(e.cnt));
          check("scan_busy at hit", 32'(scan_busy), 1);
        end
      end
      if (scan_done && !prevDone) begin
        if (exp_q.size() == 0) check("unexpected scan_done", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("event kind done", 0, 32'(e.kind));
          check("done cycle", cyc, 32'(e.cyc));
          check("star_count at done", 32'(star_count), 32'(e.cnt));
          check("scan_busy at done", 32'(scan_busy), 0);
        end
      end
      prevDone = scan_done;
    end
  end

  // ---------------- driver ----------------
  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic clear_img();
    for (int i = 0; i < NPIX; i++) img[i] = '0;
  endtask

  task automatic set_px(input int px, input int py, input int v);
    img[py * WIDTH + px] = COL_SZ'(v);
  endtask

  // mbFixed < 0 picks a random bottom row per star
  task automatic run_frame(input int mbFixed, input bit hold, input bit stPulse, input bit doReset);
    int s0, e0, d, mb, c, yStar;
    modelCount = 0;
    @(negedge clk);
    start = 1'b1;
    s0 = cyc;
    push_scan(0, s0 + 1);
    @(negedge clk);
    start = 1'b0;
    if (stPulse) begin
      wait_cyc(s0 + 2);
      start = 1'b1;          // busy: must be ignored
      @(negedge clk);
      start = 1'b0;
    end
    while (lastEv.kind == 1'b1) begin
      e0 = int'(lastEv.cyc);
      yStar = int'(lastEv.y);
      if (doReset) begin
        wait_cyc(e0 + 2);
        reset = 1'b1;
        #1;
        check("reset star_found", 32'(star_found), 0);
        check("reset x_out", 32'(x_out), 0);
        check("reset y_out", 32'(y_out), 0);
        check("reset star_count", 32'(star_count), 0);
        check("reset scan_busy", 32'(scan_busy), 0);
        check("reset scan_done", 32'(scan_done), 0);
        check("reset mem_addr", 32'(mem_addr), 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      mb = (mbFixed >= 0) ? mbFixed : $urandom_range(0, HEIGHT - 1);
      if (hold) begin
        wait_cyc(e0);
        complete_in = 1'b1;      // lands in FOUND: must be ignored
        most_bottom_in = Y_SZ'(mb);
        @(negedge clk);
        complete_in = 1'b0;
        d = $urandom_range(2, 5);
      end else begin
        d = $urandom_range(1, 4);
      end
      wait_cyc(e0 + d);
      complete_in = 1'b1;
      most_bottom_in = Y_SZ'(mb);
      c = cyc;
      modelCount++;
      if (mb >= HEIGHT - 1 || mb < yStar) push_ev(1'b0, 0, 0, c + 1);
      else push_scan((mb + 1) * WIDTH, c + 1);
      @(negedge clk);
      complete_in = 1'b0;
    end
    wait_cyc(int'(lastEv.cyc) + 2);
    check("scoreboard drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    clear_img();
    repeat (3) @(negedge clk);
    check("reset-state star_found", 32'(star_found), 0);
    check("reset-state scan_busy", 32'(scan_busy), 0);
    check("reset-state scan_done", 32'(scan_done), 0);
    check("reset-state star_count", 32'(star_count), 0);
    reset = 1'b0;
    @(negedge clk);

    // all-dark frame
    clear_img();
    run_frame(-1, 1'b0, 1'b0, 1'b0);
    // single star at (2,1), resume below row 3
    clear_img(); set_px(2, 1, 1);
    run_frame(3, 1'b0, 1'b0, 1'b0);
    // star at (0,0), stale complete held through FOUND, resume at row 3
    clear_img(); set_px(0, 0, 7); set_px(4, 3, 2);
    run_frame(2, 1'b1, 1'b0, 1'b0);
    // star on the last pixel, bottom at last row
    clear_img(); set_px(5, 5, 1);
    run_frame(5, 1'b0, 1'b0, 1'b0);
    // wrap guard: bottom above the star row ends the frame
    clear_img(); set_px(1, 2, 3); set_px(3, 4, 5);
    run_frame(0, 1'b0, 1'b1, 1'b0);
    // reset during WAIT_ACK, then rescan the same image
    clear_img(); set_px(4, 0, 2); set_px(2, 3, 6);
    run_frame(1, 1'b0, 1'b0, 1'b1);
    run_frame(1, 1'b0, 1'b0, 1'b0);

    // random frames
    for (int f = 0; f < 24; f++) begin
      for (int i = 0; i < NPIX; i++)
        img[i] = ($urandom_range(0, 7) == 0) ? COL_SZ'($urandom_range(1, 7)) : '0;
      run_frame(-1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/star_scanner.md
Name: star_scanner

Overview:
- Upstream stage of the top/bottom search FSM.
- Raster-scans the 6x6 read-only image memory, row by row, for the first pixel brighter than THRESHOLD.
- On a hit, pulses star_found with the pixel coordinates, then waits for the downstream complete flag.
- Resumes scanning at column 0 of the row after the star's reported bottom, until the frame is exhausted.

Parameters:
- X_SZ, 3, x-coordinate width.
- Y_SZ, 3, y-coordinate width.
- ADDR_SZ, 6, memory address width.
- COL_SZ, 3, pixel value width.
- WIDTH, 6, pixels per row.
- HEIGHT, 6, rows per frame.
- THRESHOLD, 0, a pixel is bright when mem_q > THRESHOLD (unsigned).
- CNT_SZ, 4, star counter width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level sampled in IDLE/DONE; begins a frame scan from (0,0).
- mem_addr  out  ADDR_SZ  read address to the image RAM, = y*WIDTH + x of the scan counters.
- mem_q  in  COL_SZ  RAM data; valid one clock after mem_addr.
- star_found  out  1  one-cycle pulse per star.
- x_out  out  X_SZ  x of the found pixel; held until the next hit.
- y_out  out  Y_SZ  y of the found pixel; held until the next hit.
- complete_in  in  1  downstream search finished.
- most_bottom_in  in  Y_SZ  downstream bottom row of the current star.
- star_count  out  CNT_SZ  stars found this frame, saturating at 2^CNT_SZ-1.
- scan_busy  out  1  high in every state except IDLE and DONE.
- scan_done  out  1  high in DONE.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE.
  - x = y = 0, x_out = y_out = 0, star_count = 0.
  - star_found = scan_busy = scan_done = 0.
- States: IDLE, SET_ADDR, WAIT_RD, CHECK, FOUND, WAIT_ACK, DONE.
- IDLE:
  - start=1 -> x=0, y=0, star_count=0, go to SET_ADDR.
- SET_ADDR -> WAIT_RD -> CHECK, unconditionally. mem_addr tracks the counters combinationally, so each pixel costs 3 clocks.
- CHECK, mem_q > THRESHOLD:
  - Latch x_out=x, y_out=y; go to FOUND.
- CHECK, dark pixel:
  - x<WIDTH-1: x+1, go to SET_ADDR.
  - x==WIDTH-1 and y<HEIGHT-1: x=0, y+1, go to SET_ADDR.
  - x==WIDTH-1 and y==HEIGHT-1: go to DONE.
- FOUND:
  - star_found=1 for exactly this cycle; go to WAIT_ACK.
  - complete_in is ignored in FOUND (stale complete from the previous star).
- WAIT_ACK:
  - star_found=0; x_out and y_out held.
  - On complete_in=1: star_count+1 (saturating), then:
    - most_bottom_in >= HEIGHT-1, or most_bottom_in < y_out (downstream wrap): go to DONE.
    - Otherwise: x=0, y=most_bottom_in+1, go to SET_ADDR.
- DONE:
  - scan_done=1; outputs held.
  - start=1 -> restart as in IDLE (star_count cleared).
- start while scan_busy is ignored.
- complete_in outside WAIT_ACK is ignored.
- Latency: a bright pixel at linear index k = y*WIDTH + x, with start high at cycle 0 from IDLE, is sampled in CHECK at cycle 3+3k; star_found is high at cycle 4+3k.
- Full dark frame: DONE entered at cycle 3+3*35+1 = 109.

Decomposition:
- Shared package star_pkg holds:
  - WIDTH, HEIGHT, X_SZ, Y_SZ, ADDR_SZ, COL_SZ, THRESHOLD, shared with the downstream block.
  - The scanner state encoding (3-bit localparams).
- One sub-module: the existing address_translator, instantiated for mem_addr.
- The RAM stays outside the block so the bench can model it directly.

Test Plan:
- All-dark frame, start pulse at cycle 0 -> no star_found; scan_done rises at cycle 109; star_count=0.
- Bright pixel only at (2,1) (k=8) -> star_found at cycle 28, x_out=2, y_out=1; then complete_in with most_bottom_in=3 -> scan resumes at (0,4) and reaches DONE; star_count=1.
- Bright at (0,0) -> star_found at cycle 4. Hold complete_in=1 through the FOUND cycle -> no early resume. Drop it, then reassert with most_bottom_in=2 -> resume at (0,3).
- Bright at (5,5) (k=35) -> star_found at cycle 109; complete_in with most_bottom_in=5 -> DONE next cycle, star_count=1.
- Wrap guard: bright at (1,2), complete_in with most_bottom_in=0 -> DONE, no further scanning.
- Reset asserted mid-WAIT_ACK -> immediately IDLE with all outputs 0. A fresh start rescans from (0,0) and re-finds the first star at the same cycle offset.
